// File: rtl/insn_obi_arbiter.sv
// Two-master OBI instruction-fetch arbiter with in-order response routing via an ID FIFO.
// Define OBI_ARB_FIXED_PRIO_EN for fixed priority (m0 wins); default is round-robin.
module insn_obi_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_req_o,
  input  logic        s_gnt_i,
  output logic [31:0] s_addr_o,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  output logic        err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  logic [MAX_OUTSTANDING-1:0] id_fifo_q;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       lock_q, lock_id_q;
  logic                       err_q;
  logic                       sel, hs, pop, head, full;
`ifndef OBI_ARB_FIXED_PRIO_EN
  logic                       rr_last_q;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = lock_id_q;
    end else if (m0_req_i && m1_req_i) begin
`ifdef OBI_ARB_FIXED_PRIO_EN
      sel = 1'b0;
`else
      sel = ~rr_last_q;
`endif
    end else if (m1_req_i) begin
      sel = 1'b1;
    end
  end

  assign full     = (cnt_q == MAX_CNT);
  assign s_req_o  = (m0_req_i | m1_req_i) & ~full;
  assign s_addr_o = sel ? m1_addr_i : m0_addr_i;
  assign hs       = s_req_o & s_gnt_i;
  assign m0_gnt_o = hs & ~sel;
  assign m1_gnt_o = hs & sel;

  // Pop reads the head before any same-cycle push lands, keeping response order intact.
  assign pop         = s_rvalid_i & (cnt_q != '0);
  assign head        = id_fifo_q[rd_ptr_q];
  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop & head;
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;
  assign err_o       = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_fifo_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      err_q     <= 1'b0;
`ifndef OBI_ARB_FIXED_PRIO_EN
      rr_last_q <= 1'b1;
`endif
    end else begin
      // An issued but ungranted request stays pinned to its master until accepted.
      if (hs) begin
        lock_q <= 1'b0;
      end else if (s_req_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= sel;
      end
      if (hs) begin
        id_fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
`ifndef OBI_ARB_FIXED_PRIO_EN
        rr_last_q           <= sel;
`endif
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (hs && !pop) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (!hs && pop) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (s_rvalid_i && (cnt_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_insn_obi_arbiter.sv
// Directed bench for insn_obi_arbiter: arbitration, locking, full stall, routing, error flag.
module tb_insn_obi_arbiter;

`ifdef OBI_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_req_i, m1_req_i, s_gnt_i, s_rvalid_i;
  logic [31:0] m0_addr_i, m1_addr_i, s_rdata_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, s_req_o, err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o, s_addr_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk_i = ~clk_i;

  insn_obi_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .m0_req_i    (m0_req_i),
    .m0_gnt_o    (m0_gnt_o),
    .m0_addr_i   (m0_addr_i),
    .m0_rvalid_o (m0_rvalid_o),
    .m0_rdata_o  (m0_rdata_o),
    .m1_req_i    (m1_req_i),
    .m1_gnt_o    (m1_gnt_o),
    .m1_addr_i   (m1_addr_i),
    .m1_rvalid_o (m1_rvalid_o),
    .m1_rdata_o  (m1_rdata_o),
    .s_req_o     (s_req_o),
    .s_gnt_i     (s_gnt_i),
    .s_addr_o    (s_addr_o),
    .s_rvalid_i  (s_rvalid_i),
    .s_rdata_i   (s_rdata_i),
    .err_o       (err_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input bit r0, input logic [31:0] a0, input bit r1, input logic [31:0] a1,
                       input bit g, input bit rv, input logic [31:0] rd);
    m0_req_i = r0; m0_addr_i = a0; m1_req_i = r1; m1_addr_i = a1;
    s_gnt_i = g; s_rvalid_i = rv; s_rdata_i = rd;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    check("rst_s_req", 32'(s_req_o), 0);
    check("rst_m0_gnt", 32'(m0_gnt_o), 0);
    check("rst_m1_gnt", 32'(m1_gnt_o), 0);
    check("rst_m0_rvalid", 32'(m0_rvalid_o), 0);
    check("rst_m1_rvalid", 32'(m1_rvalid_o), 0);
    check("rst_err", 32'(err_o), 0);
    tick();
    rst_ni = 1'b1;

    // single master fetch, response one cycle later
    drive(1, 32'h100, 0, 0, 1, 0, 0);
    @(negedge clk_i);
    check("t1_s_req", 32'(s_req_o), 1);
    check("t1_m0_gnt", 32'(m0_gnt_o), 1);
    check("t1_m1_gnt", 32'(m1_gnt_o), 0);
    check("t1_addr", s_addr_o, 32'h100);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    @(negedge clk_i);
    check("t1_m0_rvalid", 32'(m0_rvalid_o), 1);
    check("t1_m0_rdata", m0_rdata_o, 32'hDEADBEEF);
    check("t1_m1_rvalid", 32'(m1_rvalid_o), 0);
    check("t1_m1_rdata", m1_rdata_o, 0);
    tick();

    // reset restores rr_last so m0 wins the first contest
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_ni = 1'b1;

    // both request every cycle, responses overlap grants
    drive(1, 32'h10, 1, 32'h20, 1, 0, 0);
    @(negedge clk_i);
    check("t2a_m0_gnt", 32'(m0_gnt_o), 1);
    check("t2a_m1_gnt", 32'(m1_gnt_o), 0);
    check("t2a_addr", s_addr_o, 32'h10);
    tick();
    drive(1, 32'h10, 1, 32'h20, 1, 1, 32'h1111);
    @(negedge clk_i);
    check("t2b_m0_gnt", 32'(m0_gnt_o), FIXED ? 1 : 0);
    check("t2b_m1_gnt", 32'(m1_gnt_o), FIXED ? 0 : 1);
    check("t2b_addr", s_addr_o, FIXED ? 32'h10 : 32'h20);
    check("t2b_m0_rvalid", 32'(m0_rvalid_o), 1);
    check("t2b_m0_rdata", m0_rdata_o, 32'h1111);
    check("t2b_m1_rvalid", 32'(m1_rvalid_o), 0);
    tick();
    drive(1, 32'h10, 1, 32'h20, 1, 1, 32'h2222);
    @(negedge clk_i);
    check("t2c_m0_gnt", 32'(m0_gnt_o), 1);
    check("t2c_m1_gnt", 32'(m1_gnt_o), 0);
    check("t2c_m0_rvalid", 32'(m0_rvalid_o), FIXED ? 1 : 0);
    check("t2c_m1_rvalid", 32'(m1_rvalid_o), FIXED ? 0 : 1);
    check("t2c_m1_rdata", m1_rdata_o, FIXED ? 32'h0 : 32'h2222);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h3333);
    @(negedge clk_i);
    check("t2d_s_req", 32'(s_req_o), 0);
    check("t2d_m0_rvalid", 32'(m0_rvalid_o), 1);
    check("t2d_m1_rvalid", 32'(m1_rvalid_o), 0);
    tick();

    // m1 stalled by memory; lock holds it while m0 joins
    drive(0, 0, 1, 32'h200, 0, 0, 0);
    @(negedge clk_i);
    check("t3c1_s_req", 32'(s_req_o), 1);
    check("t3c1_addr", s_addr_o, 32'h200);
    check("t3c1_m1_gnt", 32'(m1_gnt_o), 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h300, 1, 32'h200, 0, 0, 0);
      @(negedge clk_i);
      check("t3_locked_addr", s_addr_o, 32'h200);
      check("t3_locked_m0_gnt", 32'(m0_gnt_o), 0);
      tick();
    end
    drive(1, 32'h300, 1, 32'h200, 1, 0, 0);
    @(negedge clk_i);
    check("t3c4_m1_gnt", 32'(m1_gnt_o), 1);
    check("t3c4_m0_gnt", 32'(m0_gnt_o), 0);
    check("t3c4_addr", s_addr_o, 32'h200);
    tick();
    drive(1, 32'h300, 0, 0, 1, 0, 0);
    @(negedge clk_i);
    check("t3c5_m0_gnt", 32'(m0_gnt_o), 1);
    check("t3c5_addr", s_addr_o, 32'h300);
    tick();

    // two outstanding: stalled, no bypass on same-cycle rvalid
    drive(1, 32'h300, 1, 32'h200, 1, 0, 0);
    @(negedge clk_i);
    check("t4_full_s_req", 32'(s_req_o), 0);
    check("t4_full_m0_gnt", 32'(m0_gnt_o), 0);
    check("t4_full_m1_gnt", 32'(m1_gnt_o), 0);
    tick();
    drive(1, 32'h300, 1, 32'h200, 1, 1, 32'hAAAA);
    @(negedge clk_i);
    check("t4_nobyp_s_req", 32'(s_req_o), 0);
    check("t4_nobyp_m0_gnt", 32'(m0_gnt_o), 0);
    check("t4_nobyp_m1_gnt", 32'(m1_gnt_o), 0);
    check("t4_m1_rvalid", 32'(m1_rvalid_o), 1);
    check("t4_m1_rdata", m1_rdata_o, 32'hAAAA);
    check("t4_m0_rdata", m0_rdata_o, 0);
    tick();
    drive(1, 32'h300, 0, 0, 1, 0, 0);
    @(negedge clk_i);
    check("t4_resume_s_req", 32'(s_req_o), 1);
    check("t4_resume_m0_gnt", 32'(m0_gnt_o), 1);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'hB);
    @(negedge clk_i);
    check("t4_r1_m0_rvalid", 32'(m0_rvalid_o), 1);
    check("t4_r1_m0_rdata", m0_rdata_o, 32'hB);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'hC);
    @(negedge clk_i);
    check("t4_r2_m0_rvalid", 32'(m0_rvalid_o), 1);
    check("t4_r2_m1_rvalid", 32'(m1_rvalid_o), 0);
    check("t4_err_clear", 32'(err_o), 0);
    tick();

    // reset with one transfer outstanding clears cnt; later rvalid is an error
    drive(1, 32'h40, 0, 0, 1, 0, 0);
    @(negedge clk_i);
    check("t5_m0_gnt", 32'(m0_gnt_o), 1);
    tick();
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_ni = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 32'h5);
    @(negedge clk_i);
    check("t5_m0_rvalid", 32'(m0_rvalid_o), 0);
    check("t5_m1_rvalid", 32'(m1_rvalid_o), 0);
    check("t5_m0_rdata", m0_rdata_o, 0);
    check("t5_err_pre", 32'(err_o), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    check("t5_err_set", 32'(err_o), 1);
    tick();
    drive(1, 32'h50, 0, 0, 1, 0, 0);
    @(negedge clk_i);
    check("t5_gnt_after_err", 32'(m0_gnt_o), 1);
    check("t5_err_sticky", 32'(err_o), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk_i);
    check("t5_err_sticky2", 32'(err_o), 1);
    rst_ni = 1'b0;
    #1;
    check("t5_err_rst", 32'(err_o), 0);
    tick();
    rst_ni = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
